// File: rtl/cdc_handshake_tx_arbiter.sv
// cdc_handshake_tx_arbiter: round-robin source-side arbiter driving one toggle-handshake CDC data channel
// Ports: Clk, sync_rst_n (synchronous active-low reset); ReqValid/ReqData per-requester inputs,
// ReqReady one-hot combinational accept; TxData/TxTag/TxToggle registered crossing bus;
// AckToggle synchronized far-side ack; Busy (not IDLE); TimeoutError sticky ack-timeout flag.
// Optional: define CDC_HANDSHAKE_TIMEOUT_EN to add the ack timeout that halts until reset.
module cdc_handshake_tx_arbiter #(
  parameter int DATA_BITWIDTH = 8,
  parameter int REQUESTER_COUNT = 4,
  parameter int TAG_BITWIDTH = $clog2(REQUESTER_COUNT),
  parameter int SETUP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic Clk,
  input  logic sync_rst_n,
  input  logic [REQUESTER_COUNT-1:0] ReqValid,
  input  logic [REQUESTER_COUNT*DATA_BITWIDTH-1:0] ReqData,
  output logic [REQUESTER_COUNT-1:0] ReqReady,
  output logic [DATA_BITWIDTH-1:0] TxData,
  output logic [TAG_BITWIDTH-1:0] TxTag,
  output logic TxToggle,
  input  logic AckToggle,
  output logic Busy,
  output logic TimeoutError
);
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, HALT} state_t;
  localparam int WAIT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_BITS-1:0] waitCnt;
  logic timeoutFlag;
`else
  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} state_t;
`endif
  state_t state, stateNext;
  logic [TAG_BITWIDTH-1:0] rrPtr, grantIdx, grantOfs;
  logic [TAG_BITWIDTH:0] grantSum;
  logic [REQUESTER_COUNT-1:0] validRot;
  logic [3:0] setupCnt;
  logic accept;
  // Rotate so bit 0 is the pointer position; lowest set bit is the round-robin winner.
  assign validRot = REQUESTER_COUNT'({ReqValid, ReqValid} >> rrPtr);
  always_comb begin
    grantOfs = '0;
    for (int k = REQUESTER_COUNT - 1; k >= 0; k--)
      if (validRot[k]) grantOfs = TAG_BITWIDTH'(k);
    grantSum = {1'b0, rrPtr} + {1'b0, grantOfs};
    grantIdx = (grantSum >= (TAG_BITWIDTH+1)'(REQUESTER_COUNT))
             ? TAG_BITWIDTH'(grantSum - (TAG_BITWIDTH+1)'(REQUESTER_COUNT))
             : grantSum[TAG_BITWIDTH-1:0];
  end
  assign accept = (state == IDLE) && (|ReqValid);
  assign ReqReady = (sync_rst_n && accept) ? (REQUESTER_COUNT'(1) << grantIdx) : '0;
  assign Busy = state != IDLE;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     stateNext = accept ? SETUP : IDLE;
      SETUP:    stateNext = (setupCnt == 4'd0) ? WAIT_ACK : SETUP;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
      WAIT_ACK: stateNext = (AckToggle == TxToggle) ? IDLE
                          : (waitCnt == WAIT_BITS'(TIMEOUT_CYCLES - 1)) ? HALT : WAIT_ACK;
`else
      WAIT_ACK: stateNext = (AckToggle == TxToggle) ? IDLE : WAIT_ACK;
`endif
      default:  stateNext = state;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!sync_rst_n) begin
      state <= IDLE;
      TxData <= '0;
      TxTag <= '0;
      TxToggle <= 1'b0;
      rrPtr <= '0;
      setupCnt <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        TxData <= ReqData[grantIdx*DATA_BITWIDTH +: DATA_BITWIDTH];
        TxTag <= grantIdx;
        rrPtr <= (32'(grantIdx) == REQUESTER_COUNT - 1) ? '0 : grantIdx + 1'b1;
        setupCnt <= 4'(SETUP_CYCLES - 1);
      end else if (state == SETUP && setupCnt != 4'd0) begin
        setupCnt <= setupCnt - 4'd1;
      end
      if (state == SETUP && setupCnt == 4'd0) TxToggle <= ~TxToggle;
    end
  end
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (!sync_rst_n) begin
      waitCnt <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      waitCnt <= (state == WAIT_ACK) ? waitCnt + 1'b1 : '0;
      if (state == WAIT_ACK && stateNext == HALT) timeoutFlag <= 1'b1;
    end
  end
  assign TimeoutError = timeoutFlag;
`else
  assign TimeoutError = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_handshake_tx_arbiter.sv
// tb_cdc_handshake_tx_arbiter: directed bench with a transaction-level reference model and per-cycle compare
module tb_cdc_handshake_tx_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int SC = 2;
  localparam int TO = 16;
  logic Clk = 1'b0;
  logic sync_rst_n = 1'b0;
  logic AckToggle = 1'b0;
  logic [N-1:0] ReqValid = '0;
  logic [N*DW-1:0] ReqData = '0;
  logic [N-1:0] ReqReady;
  logic [DW-1:0] TxData;
  logic [1:0] TxTag;
  logic TxToggle, Busy, TimeoutError;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit ok;
  cdc_handshake_tx_arbiter #(
    .DATA_BITWIDTH(DW), .REQUESTER_COUNT(N), .SETUP_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk), .sync_rst_n(sync_rst_n), .ReqValid(ReqValid), .ReqData(ReqData),
    .ReqReady(ReqReady), .TxData(TxData), .TxTag(TxTag), .TxToggle(TxToggle),
    .AckToggle(AckToggle), .Busy(Busy), .TimeoutError(TimeoutError)
  );
  always #5 Clk = ~Clk;
  // Model: a transfer is "busy" from accept until an ack matching the flipped toggle is seen;
  // the toggle flips SC edges after accept.
  logic mBusy = 1'b0, mTog = 1'b0, mFlipped = 1'b0, mHalt = 1'b0, mErr = 1'b0;
  logic [DW-1:0] mData = '0;
  int mTag = 0, mPtr = 0, mAge = 0, mWait = 0;
  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  function automatic logic [N-1:0] exp_ready();
    return (sync_rst_n && !mBusy && |ReqValid) ? (N'(1) << winner(ReqValid, mPtr)) : '0;
  endfunction
  always @(posedge Clk) begin
    if (!sync_rst_n) begin
      mBusy <= 0; mData <= '0; mTag <= 0; mTog <= 0; mPtr <= 0;
      mFlipped <= 0; mAge <= 0; mWait <= 0; mHalt <= 0; mErr <= 0;
    end else if (!mBusy) begin
      if (|ReqValid) begin
        mData <= ReqData[winner(ReqValid, mPtr)*DW +: DW];
        mTag <= winner(ReqValid, mPtr);
        mPtr <= (winner(ReqValid, mPtr) + 1) % N;
        mBusy <= 1; mAge <= 0; mFlipped <= 0; mWait <= 0;
      end
    end else if (!mHalt) begin
      mAge <= mAge + 1;
      if (!mFlipped) begin
        if (mAge + 1 == SC) begin mTog <= ~mTog; mFlipped <= 1; end
      end else if (AckToggle == mTog) begin
        mBusy <= 0;
      end
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
      else begin
        mWait <= mWait + 1;
        if (mWait + 1 == TO) begin mHalt <= 1; mErr <= 1; end
      end
`endif
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask
  always @(negedge Clk) begin
    cyc++;
    chk("ReqReady", 32'(ReqReady), 32'(exp_ready()));
    chk("Busy", 32'(Busy), 32'(mBusy));
    chk("TxData", 32'(TxData), 32'(mData));
    chk("TxTag", 32'(TxTag), mTag);
    chk("TxToggle", 32'(TxToggle), 32'(mTog));
    chk("TimeoutError", 32'(TimeoutError), 32'(mErr));
  end
  task automatic do_reset();
    sync_rst_n = 1'b0;
    AckToggle = 1'b0;
    repeat (2) @(posedge Clk);
    #1 sync_rst_n = 1'b1;
  endtask
  task automatic wait_ready(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge Clk);
      found = |ReqReady;
    end
  endtask
  initial begin
    ReqData = {8'h44, 8'hA5, 8'h22, 8'h11};
    ReqValid = 4'b1111;
    repeat (3) begin
      @(negedge Clk);
      chk("rst_ready", 32'(ReqReady), 0);
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_tog", 32'(TxToggle), 0);
      chk("rst_data", 32'(TxData), 0);
    end
    @(posedge Clk); #1;
    ReqValid = 4'b0000;
    sync_rst_n = 1'b1;
    ReqValid = 4'b0100;
    @(negedge Clk);
    chk("single_ready", 32'(ReqReady), 32'h4);
    @(posedge Clk); #1;
    ReqValid = 4'b0000;
    @(negedge Clk);
    chk("single_data", 32'(TxData), 32'hA5);
    chk("single_tag", 32'(TxTag), 2);
    chk("single_tog0", 32'(TxToggle), 0);
    @(negedge Clk);
    chk("single_tog1", 32'(TxToggle), 0);
    @(negedge Clk);
    chk("single_tog2", 32'(TxToggle), 1);
    repeat (2) @(posedge Clk);
    #1 AckToggle = 1'b1;
    @(negedge Clk);
    chk("single_busy_hold", 32'(Busy), 1);
    @(negedge Clk);
    chk("single_busy_fall", 32'(Busy), 0);
    @(posedge Clk); #1;
    do_reset();
    ReqValid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ready(ok);
      chk("rr_grant_seen", 32'(ok), 1);
      chk("rr_order", 32'(ReqReady), 32'(1 << (i % 4)));
      @(posedge Clk); #1;
      ReqData = $urandom;
      @(negedge Clk);
      chk("rr_tag", 32'(TxTag), i % 4);
      @(posedge Clk); #1;
      for (int t = 0; t < 20 && TxToggle === AckToggle; t++) begin
        @(posedge Clk); #1;
      end
      chk("rr_toggle_seen", 32'(TxToggle !== AckToggle), 1);
      repeat (2) @(posedge Clk);
      #1 AckToggle = TxToggle;
    end
    @(posedge Clk); #1;
    do_reset();
    ReqValid = 4'b0011;
    wait_ready(ok);
    chk("stall_grant", 32'(ReqReady), 32'h1);
    repeat (3) @(posedge Clk);
    #1;
    repeat (100) begin
      @(negedge Clk);
      chk("stall_busy", 32'(Busy), 1);
      chk("stall_ready", 32'(ReqReady), 0);
      chk("stall_tog", 32'(TxToggle), 1);
    end
    @(posedge Clk); #1;
    do_reset();
    ReqValid = 4'b0100;
    wait_ready(ok);
    chk("mid_grant", 32'(ReqReady), 32'h4);
    repeat (4) @(posedge Clk);
    #1;
    chk("mid_busy_before", 32'(Busy), 1);
    chk("mid_tog_before", 32'(TxToggle), 1);
    sync_rst_n = 1'b0;
    AckToggle = 1'b0;
    ReqValid = 4'b1111;
    @(posedge Clk);
    @(negedge Clk);
    chk("mid_tog_after", 32'(TxToggle), 0);
    chk("mid_busy_after", 32'(Busy), 0);
    @(posedge Clk); #1;
    sync_rst_n = 1'b1;
    wait_ready(ok);
    chk("mid_next_grant", 32'(ReqReady), 32'h1);
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
    @(posedge Clk); #1;
    do_reset();
    ReqValid = 4'b0001;
    wait_ready(ok);
    repeat (18) @(posedge Clk);
    #1 chk("to_not_yet", 32'(TimeoutError), 0);
    @(posedge Clk);
    #1 chk("to_set", 32'(TimeoutError), 1);
    repeat (10) begin
      @(negedge Clk);
      chk("to_sticky", 32'(TimeoutError), 1);
      chk("to_no_ready", 32'(ReqReady), 0);
    end
    @(posedge Clk); #1;
    do_reset();
    chk("to_cleared", 32'(TimeoutError), 0);
`endif
    @(posedge Clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
